// File: rtl/fill_check_pkg.sv
// Shared types for the fill-constant checker: fill modes, FSM states and index sizing.
package fill_check_pkg;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_ONE  = 2'd1,
    FILL_ALT  = 2'd2,
    FILL_IDX  = 2'd3
  } fill_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/fill_gen.sv
// Combinational fill-pattern generator: WIDTH-bit pattern for a given mode and channel index.
module fill_gen
  import fill_check_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 2,
  localparam int IDX_W    = idx_width(CHANNELS)
) (
  input  fill_mode_e       mode_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [WIDTH-1:0] pattern_o
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    pattern_o = '0;
    unique case (mode_i)
      FILL_ZERO: pattern_o = '0;
      FILL_ONE:  pattern_o = '1;
      FILL_ALT: begin
        for (int i = 0; i < WIDTH; i++) pattern_o[i] = i[0];
      end
      // The size cast zero-extends or truncates the index to the channel width.
      FILL_IDX:  pattern_o = WIDTH'(idx_i);
      default:   pattern_o = '0;
    endcase
  end

endmodule

// File: rtl/fill_const_checker.sv
// Sweeps CHANNELS registers with a fill pattern and checks each against an independent
// expected pattern. Optional fault injection on the store path: FILL_CHECK_INJECT_EN.
module fill_const_checker
  import fill_check_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 2,
  parameter  int COUNT_W  = 8,
  localparam int IDX_W    = idx_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [1:0]                mode_i,
  input  logic                      abort_i,
  input  logic                      clear_i,
`ifdef FILL_CHECK_INJECT_EN
  input  logic                      inject_i,
  input  logic [IDX_W-1:0]          inject_ch_i,
`endif
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CHANNELS-1:0]       pass_o,
  output logic [COUNT_W-1:0]        err_count_o,
  output logic [CHANNELS*WIDTH-1:0] data_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  state_e                           state_q, state_d;
  fill_mode_e                       mode_q, mode_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   chan_q, chan_d;
  logic [CHANNELS-1:0]              pass_q, pass_d;
  logic [COUNT_W-1:0]               err_q, err_d;
  logic                             busy_q, done_q;

  logic [WIDTH-1:0] store_pat, exp_pat, store_val;
  logic             inject_hit;

  // Store and expected patterns come from separate generator instances.
  fill_gen #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_store_gen (
    .mode_i    (mode_q),
    .idx_i     (idx_q),
    .pattern_o (store_pat)
  );

  fill_gen #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_exp_gen (
    .mode_i    (mode_q),
    .idx_i     (idx_q),
    .pattern_o (exp_pat)
  );

`ifdef FILL_CHECK_INJECT_EN
  assign inject_hit = inject_i && (inject_ch_i == idx_q);
`else
  assign inject_hit = 1'b0;
`endif

  always_comb begin
    store_val    = store_pat;
    store_val[0] = store_pat[0] ^ inject_hit;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    chan_d  = chan_q;
    pass_d  = pass_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (clear_i) err_d = '0;
        if (start_i) begin
          mode_d  = fill_mode_e'(mode_i);
          pass_d  = '0;
          idx_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        chan_d[idx_q] = store_val;
        state_d       = CHECK;
      end
      CHECK: begin
        pass_d[idx_q] = (chan_q[idx_q] == exp_pat);
        if ((chan_q[idx_q] != exp_pat) && (err_q != '1)) err_d = err_q + COUNT_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FILL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over every transition and freezes the visible results.
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = idx_q;
      chan_d  = chan_q;
      pass_d  = pass_q;
      err_d   = err_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= FILL_ZERO;
      idx_q   <= '0;
      chan_q  <= '0;
      pass_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign data_o      = chan_q;

endmodule
